// File: rtl/neuron_pkg.sv
// neuron_pkg: shared FSM state encoding and leaky-ReLU slope shift for neuron_act_stage.
package neuron_pkg;
  typedef enum logic [1:0] {IDLE, BIAS, ACT, PUSH} state_t;
  localparam int ACT_LEAK_SHIFT = 3;
endpackage

// File: rtl/act_fifo.sv
// act_fifo: synchronous show-ahead FIFO; head is presented whenever non-empty.
module act_fifo #(
  parameter int OUT_W = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [OUT_W-1:0] i_data,
  input  logic             i_pop,
  output logic [OUT_W-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [OUT_W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_cnt;
  logic w_pop, w_push;
  assign w_pop = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);
  assign o_full = r_cnt == (AW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign o_data = o_empty ? '0 : r_mem[r_rd];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end
endmodule

// File: rtl/neuron_act_stage.sv
// neuron_act_stage: bias add, ReLU and saturating requantization of neuron results into a FIFO.
// Define NEURON_ACT_LEAKY_EN to pass negatives through a leaky slope instead of clamping to zero.
module neuron_act_stage
  import neuron_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8,
  parameter int SHIFT = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_ready,
  input  logic [IN_W-1:0]  bias,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ack,
  output logic             full,
  output logic             busy,
  output logic             drop_err
);
  localparam logic signed [IN_W:0] P_MAX = (IN_W+1)'((1 << (OUT_W-1)) - 1);
  localparam logic signed [IN_W:0] P_MIN = ~P_MAX;
  state_t r_state, w_next;
  logic r_in_ready_d, r_drop;
  logic [IN_W-1:0] r_data, r_bias;
  logic signed [IN_W:0] r_sum, w_pos;
  logic [OUT_W-1:0] r_res, w_act;
  logic w_event, w_push, w_empty;
  assign w_event = in_ready & ~r_in_ready_d;
  assign busy = r_state != IDLE;
  assign out_valid = ~w_empty;
  assign drop_err = r_drop;
  assign w_pos = r_sum >>> SHIFT;
`ifdef NEURON_ACT_LEAKY_EN
  logic signed [IN_W:0] w_neg;
  assign w_neg = r_sum >>> (SHIFT + ACT_LEAK_SHIFT);
  assign w_act = r_sum[IN_W] ? (w_neg < P_MIN ? P_MIN[OUT_W-1:0] : w_neg[OUT_W-1:0])
                             : (w_pos > P_MAX ? P_MAX[OUT_W-1:0] : w_pos[OUT_W-1:0]);
`else
  assign w_act = r_sum[IN_W] ? '0 : (w_pos > P_MAX ? P_MAX[OUT_W-1:0] : w_pos[OUT_W-1:0]);
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    w_push = 1'b0;
    unique case (r_state)
      IDLE: w_next = w_event ? BIAS : IDLE;
      BIAS: w_next = ACT;
      ACT:  w_next = PUSH;
      PUSH: begin
        w_push = ~full | out_ack;
        w_next = w_push ? IDLE : PUSH;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_in_ready_d <= 1'b0;
      r_drop <= 1'b0;
      r_data <= '0;
      r_bias <= '0;
      r_sum <= '0;
      r_res <= '0;
    end else begin
      r_in_ready_d <= in_ready;
      if (w_event && r_state != IDLE) r_drop <= 1'b1;
      if (w_event && r_state == IDLE) begin
        r_data <= in_data;
        r_bias <= bias;
      end
      // one guard bit makes the bias add overflow-free
      if (r_state == BIAS) r_sum <= {r_data[IN_W-1], r_data} + {r_bias[IN_W-1], r_bias};
      if (r_state == ACT) r_res <= w_act;
    end
  end
  act_fifo #(.OUT_W(OUT_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .i_push(w_push),
    .i_data(r_res),
    .i_pop(out_ack),
    .o_data(out_data),
    .o_full(full),
    .o_empty(w_empty)
  );
endmodule

// File: doc/neuron_act_stage.md
# neuron_act_stage

Downstream stage of `single_neuron_2`: consumes each 16-bit dot-product result announced by the neuron's `ready` and adds a per-neuron bias. It then applies ReLU (optionally leaky) and requantizes to a signed 8-bit activation by arithmetic right shift with saturation. Results are buffered in a small show-ahead FIFO, in the same 8-bit format the neuron reads as input vectors, so the next layer can drain them with a valid/ack handshake.

## Interface
- `IN_W`, 16, width of neuron result and bias (signed two's complement)
- `OUT_W`, 8, width of activation output (signed)
- `SHIFT`, 4, requantization right-shift amount
- `DEPTH`, 4, FIFO entries (power of two, ≥2)

- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: asynchronous, active-low reset
- `in_data` in IN_W: neuron result (`single_neuron_2` `out`)
- `in_ready` in 1: neuron `ready`; level or pulse accepted
- `bias` in IN_W: signed bias, sampled together with `in_data`
- `out_data` out OUT_W: FIFO head activation
- `out_valid` out 1: FIFO non-empty
- `out_ack` in 1: consumer pops head when `out_valid & out_ack`
- `full` out 1: FIFO holds DEPTH entries
- `busy` out 1: FSM not in IDLE
- `drop_err` out 1: sticky; a result was offered while busy and lost

## Operation
- Capture event: `in_ready` high and registered `in_ready_d` low, i.e. a rising edge. `in_ready_d` resets to 0, so `in_ready` high at reset release gives one event.
- FSM states and transitions:
  - IDLE: on event, latch `in_data` and `bias`, then go to BIAS.
  - BIAS: `sum = sext(in_data) + sext(bias)` at IN_W+1 bits, no overflow possible; go to ACT.
  - ACT: compute `res`, go to PUSH.
  - PUSH: write `res` into the FIFO if not full, or if full with a pop in the same cycle; then go to IDLE. Otherwise hold PUSH.
- Activation:
  - `sum < 0`: `res = 0`.
  - `sum ≥ 0`: `q = sum >>> SHIFT`, saturated to `2^(OUT_W-1)-1`.
  - The shift truncates toward −∞.
- Event while not IDLE: the result is discarded, `drop_err` is set and held until reset, and the FSM is unaffected.
- FIFO:
  - Show-ahead: `out_data` is the head whenever `out_valid`.
  - Simultaneous push and pop is legal in any fill state, and the count is unchanged.
  - Pop on empty is ignored.
  - Pointers wrap modulo DEPTH.
- Reset asserted in any state returns the FSM to IDLE, empties the FIFO and clears `drop_err`. An in-flight result is lost.

## Timing
- Reset values: `out_data`=0, `out_valid`=0, `full`=0, `busy`=0, `drop_err`=0.
- Capture at edge E0; sum at E1; activation at E2; FIFO write at E3.
- `out_valid` is high after E3 when the FIFO was empty: 3-cycle latency from capture to visible result.
- `busy` is high from after E0 through E3 inclusive. The earliest next capture is E4, so throughput is one result per 4 cycles.
- Full stall: PUSH holds. The write happens at the edge where `out_ack` pops, or at the first edge after `full` drops.
- `full` and `out_valid` are registered-state decodes with no combinational path from `out_ack`.

## Configuration
- `NEURON_ACT_LEAKY_EN`:
  - Defined: for `sum < 0`, `res = sum >>> (SHIFT+3)`, saturated to `-2^(OUT_W-1)`.
  - Undefined: negatives clamp to 0 (plain ReLU).
  - All other behaviour is identical.

## Structure
- `neuron_pkg` holds the FSM state enum (IDLE, BIAS, ACT, PUSH) and `ACT_LEAK_SHIFT = 3`.
- Sub-module `act_fifo` (parameters OUT_W, DEPTH) provides the synchronous show-ahead FIFO with push, pop, full and empty. It uses the same `clk` and `rst`.
- The FSM, edge detect and arithmetic live in `neuron_act_stage`.

## Test plan
- **Positive result:** `in_data`=0x0320, `bias`=0x0010, capture → after 3 cycles `out_valid`=1 and `out_data`=0x33. Then `out_ack` → `out_valid`=0.
- **Negative result:** `in_data`=0xFF00, `bias`=0 → `out_data`=0x00. With `NEURON_ACT_LEAKY_EN` → `out_data`=0xFE.
- **Saturation:** `in_data`=0x7FFF, `bias`=0x7FFF → `out_data`=0x7F. Without the leaky macro, `in_data`=0x8000, `bias`=0x8000 → 0x00.
- **Backpressure and drop:** `out_ack`=0 with five captures spaced 4 cycles apart (`busy` is low at each) → `full`=1 after the 4th and the 5th holds PUSH with `busy`=1. A 6th capture while busy → `drop_err`=1. One `out_ack` → the 5th is written on that edge, `full` stays 1, and the drained order is results 2 to 5.
- **Held `in_ready`:** `in_ready` held high 50 cycles → exactly one FIFO entry and `drop_err`=0.
- **Reset mid-operation:** `rst` low during ACT with 2 entries queued → all outputs at reset values immediately. After release, nothing appears unless a new capture occurs.
